// File: rtl/popcount_pkg.sv
// Shared defaults and arithmetic helpers for the streaming popcount block.
package popcount_pkg;

   localparam int DEF_DATA_W  = 32;
   localparam int DEF_CHUNK_W = 8;
   localparam int DEF_ACC_W   = 16;

   // Bits needed to hold a count of 0..n.
   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

   // Saturating-add helper: true when a + b exceeds 2^w - 1, in which case the
   // caller clamps to all-ones. Operands are zero-extended to 32 bits.
   function automatic logic sat_ovf(input logic [31:0] a, input logic [31:0] b, input int w);
      logic [32:0] sum;
      logic [32:0] lim;
      sum = {1'b0, a} + {1'b0, b};
      lim = (33'd1 << w) - 33'd1;
      return sum > lim;
   endfunction

endpackage

// File: rtl/popcount_chunk.sv
// Combinational ones counter for a W-bit slice: full/half adders at the leaves,
// partial counts summed up a tree that prefers groups of three bits.
module popcount_chunk #(
   parameter int W = 8
) (
   input  logic [W-1:0]             i_bits,
   output logic [$clog2(W+1)-1:0]   o_cnt
);

   generate
      if (W == 1) begin : g_bit
         assign o_cnt = i_bits;
      end else if (W == 2) begin : g_ha
         assign o_cnt = {i_bits[0] & i_bits[1], i_bits[0] ^ i_bits[1]};
      end else if (W == 3) begin : g_fa
         logic w_p;
         assign w_p   = i_bits[0] ^ i_bits[1];
         assign o_cnt = {(i_bits[0] & i_bits[1]) | (w_p & i_bits[2]), w_p ^ i_bits[2]};
      end else begin : g_split
         localparam int WL = ((W / 2) >= 3) ? 3 * ((W / 2) / 3) : (W / 2);
         localparam int WH = W - WL;
         localparam int OW = $clog2(W + 1);
         logic [$clog2(WL+1)-1:0] w_lo;
         logic [$clog2(WH+1)-1:0] w_hi;

         popcount_chunk #(.W(WL)) u_lo (
            .i_bits (i_bits[WL-1:0]),
            .o_cnt  (w_lo)
         );
         popcount_chunk #(.W(WH)) u_hi (
            .i_bits (i_bits[W-1:WL]),
            .o_cnt  (w_hi)
         );

         assign o_cnt = OW'(w_lo) + OW'(w_hi);
      end
   endgenerate

endmodule

// File: rtl/popcount_stream.sv
// Two-stage streaming popcount: per-word counts or saturating per-frame totals,
// with an elastic output register whose stall backpressures the source.
module popcount_stream
   import popcount_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int CHUNK_W = DEF_CHUNK_W,
   parameter int ACC_W   = DEF_ACC_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   input  logic              mode,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_count,
   output logic              out_sat
);

   localparam int NCHUNK      = DATA_W / CHUNK_W;
   localparam int CNT_CHUNK_W = cnt_w(CHUNK_W);
   localparam int WC_W        = cnt_w(DATA_W);

   logic                   w_adv;
   logic                   w_ovf;
   logic [WC_W-1:0]        w_wc;
   logic [ACC_W-1:0]       w_acc_sum;
   logic [CNT_CHUNK_W-1:0] w_chunk_cnt [NCHUNK];

   logic                   r_s1_valid;
   logic                   r_s1_last;
   logic                   r_s1_mode;
   logic [CNT_CHUNK_W-1:0] r_s1_cnt [NCHUNK];
   logic [ACC_W-1:0]       r_acc;
   logic                   r_sticky;
   logic                   r_out_valid;
   logic [ACC_W-1:0]       r_out_count;
   logic                   r_out_sat;

   generate
      for (genvar g = 0; g < NCHUNK; g++) begin : g_chunk
         popcount_chunk #(.W(CHUNK_W)) u_chunk (
            .i_bits (in_data[g*CHUNK_W +: CHUNK_W]),
            .o_cnt  (w_chunk_cnt[g])
         );
      end
   endgenerate

   assign w_adv    = !r_out_valid || out_ready;
   assign in_ready = w_adv;

   always_comb begin
      w_wc = '0;
      for (int i = 0; i < NCHUNK; i++) begin
         w_wc = w_wc + WC_W'(r_s1_cnt[i]);
      end
   end

   // Running total plus this word, clamped to all-ones on overflow.
   always_comb begin
      w_ovf     = sat_ovf(32'(r_acc), 32'(w_wc), ACC_W);
      w_acc_sum = w_ovf ? '1 : (r_acc + ACC_W'(w_wc));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_last  <= 1'b0;
         r_s1_mode  <= 1'b0;
         for (int i = 0; i < NCHUNK; i++) begin
            r_s1_cnt[i] <= '0;
         end
      end else if (clr) begin
         r_s1_valid <= 1'b0;
      end else if (w_adv) begin
         r_s1_valid <= in_valid;
         r_s1_last  <= in_last;
         r_s1_mode  <= mode;
         r_s1_cnt   <= w_chunk_cnt;
      end
   end

   // Per-word results bypass the accumulator so they may interleave with a frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc       <= '0;
         r_sticky    <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_count <= '0;
         r_out_sat   <= 1'b0;
      end else if (clr) begin
         r_acc       <= '0;
         r_sticky    <= 1'b0;
         r_out_valid <= 1'b0;
      end else if (w_adv) begin
         if (!r_s1_valid) begin
            r_out_valid <= 1'b0;
         end else if (!r_s1_mode) begin
            r_out_count <= ACC_W'(w_wc);
            r_out_sat   <= 1'b0;
            r_out_valid <= 1'b1;
         end else if (!r_s1_last) begin
            r_acc       <= w_acc_sum;
            r_sticky    <= r_sticky | w_ovf;
            r_out_valid <= 1'b0;
         end else begin
            r_out_count <= w_acc_sum;
            r_out_sat   <= r_sticky | w_ovf;
            r_out_valid <= 1'b1;
            r_acc       <= '0;
            r_sticky    <= 1'b0;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_count = r_out_count;
   assign out_sat   = r_out_sat;

endmodule

// File: tb/tb_popcount_stream.sv
// Bench for popcount_stream: a default instance (ACC_W=16) and a narrow one
// (ACC_W=6) share stimulus; a frame-level scoreboard predicts both.
module tb_popcount_stream;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clr = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_data = '0;
   logic        in_last = 1'b0;
   logic        mode = 1'b0;
   logic        out_ready = 1'b0;

   logic        in_ready, out_valid, out_sat;
   logic [15:0] out_count;
   logic        in_ready6, out_valid6, out_sat6;
   logic [5:0]  out_count6;

   always #5 clk = ~clk;

   popcount_stream #(.DATA_W(32), .CHUNK_W(8), .ACC_W(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_last(in_last), .mode(mode),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_count(out_count), .out_sat(out_sat)
   );

   popcount_stream #(.DATA_W(32), .CHUNK_W(8), .ACC_W(6)) u_dut6 (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .in_valid(in_valid), .in_ready(in_ready6), .in_data(in_data),
      .in_last(in_last), .mode(mode),
      .out_valid(out_valid6), .out_ready(out_ready),
      .out_count(out_count6), .out_sat(out_sat6)
   );

   typedef struct {
      int cnt16;
      bit sat16;
      int cnt6;
      bit sat6;
   } res_t;

   typedef struct {
      logic [31:0] data;
      int          exp;
   } vec_t;

   res_t exp_q[$];
   int   macc [2];
   bit   mst  [2];
   int   n_pass = 0;
   int   n_total = 0;

   task automatic chk(input string name, input longint act, input longint req);
      n_total++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got %0d required %0d", name, act, req);
   endtask

   // Frame-level reference: counts via $countones, totals clamped per width.
   function automatic void model_beat(input logic [31:0] d, input bit m, input bit l);
      int   wc;
      int   s [2];
      int   lim [2];
      res_t r;
      wc     = $countones(d);
      lim[0] = 65535;
      lim[1] = 63;
      if (!m) begin
         r.cnt16 = wc; r.sat16 = 1'b0; r.cnt6 = wc; r.sat6 = 1'b0;
         exp_q.push_back(r);
      end else begin
         for (int k = 0; k < 2; k++) begin
            s[k] = macc[k] + wc;
            if (s[k] > lim[k]) begin
               s[k]   = lim[k];
               mst[k] = 1'b1;
            end
         end
         if (l) begin
            r.cnt16 = s[0]; r.sat16 = mst[0]; r.cnt6 = s[1]; r.sat6 = mst[1];
            exp_q.push_back(r);
            for (int k = 0; k < 2; k++) begin
               macc[k] = 0;
               mst[k]  = 1'b0;
            end
         end else begin
            for (int k = 0; k < 2; k++) macc[k] = s[k];
         end
      end
   endfunction

   function automatic void model_flush();
      exp_q.delete();
      for (int k = 0; k < 2; k++) begin
         macc[k] = 0;
         mst[k]  = 1'b0;
      end
   endfunction

   // Called at a falling edge; drives one cycle of inputs, scores the outputs,
   // and returns at the next falling edge.
   task automatic cycle(input bit v, input logic [31:0] d, input bit l, input bit m,
                        input bit ordy, input bit c, output bit acc);
      logic ov16, ov6;
      res_t e;
      ov16 = out_valid;
      ov6  = out_valid6;
      in_valid = v; in_data = d; in_last = l; mode = m; out_ready = ordy; clr = c;
      #1;
      chk("in_ready", in_ready, !ov16 || ordy);
      chk("in_ready6", in_ready6, !ov6 || ordy);
      if (ov16 || ov6) begin
         chk("pending_result", int'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            e = exp_q[0];
            if (ov16) begin
               chk("count16", out_count, e.cnt16);
               chk("sat16", out_sat, e.sat16);
            end
            if (ov6) begin
               chk("count6", out_count6, e.cnt6);
               chk("sat6", out_sat6, e.sat6);
            end
            if (ordy) void'(exp_q.pop_front());
         end
      end
      acc = v && (!ov16 || ordy) && !c;
      if (c) model_flush();
      else if (acc) model_beat(d, m, l);
      @(negedge clk);
   endtask

   task automatic idle(input bit ordy);
      bit a;
      cycle(1'b0, 32'h0, 1'b0, 1'b0, ordy, 1'b0, a);
   endtask

   task automatic do_reset();
      in_valid = 1'b0; clr = 1'b0; out_ready = 1'b0;
      rst_n = 1'b0;
      model_flush();
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_count", out_count, 0);
      chk("rst_out_sat", out_sat, 0);
      chk("rst_out_valid6", out_valid6, 0);
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready", in_ready, 1);
      @(negedge clk);
   endtask

   initial begin
      bit   a;
      int   idx;
      vec_t tbl [6];
      logic [31:0] beats [8];

      model_flush();
      repeat (2) @(negedge clk);
      do_reset();

      tbl[0] = '{32'hFFFF_FFFF, 32};
      tbl[1] = '{32'h0000_0000, 0};
      tbl[2] = '{32'h8000_0001, 2};
      tbl[3] = '{32'h0000_000F, 4};
      tbl[4] = '{32'hAAAA_AAAA, 16};
      tbl[5] = '{32'h1234_5678, 13};
      for (int i = 0; i < 6; i++) begin
         cycle(1'b1, tbl[i].data, 1'b0, 1'b0, 1'b1, 1'b0, a);
         chk("tbl_not_yet_valid", out_valid, 0);
         idle(1'b1);
         chk("tbl_valid", out_valid, 1);
         chk("tbl_count", out_count, tbl[i].exp);
         chk("tbl_count6", out_count6, tbl[i].exp);
         idle(1'b1);
      end

      // back-to-back per-word beats
      cycle(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0, a);
      cycle(1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0, a);
      chk("b2b_first", out_count, 32);
      cycle(1'b1, 32'h8000_0001, 1'b0, 1'b0, 1'b1, 1'b0, a);
      chk("b2b_second_valid", out_valid, 1);
      chk("b2b_second", out_count, 0);
      idle(1'b1);
      chk("b2b_third_valid", out_valid, 1);
      chk("b2b_third", out_count, 2);
      idle(1'b1);
      chk("b2b_drained", out_valid, 0);

      // accumulate frame
      cycle(1'b1, 32'h0000_000F, 1'b0, 1'b1, 1'b1, 1'b0, a);
      cycle(1'b1, 32'h0000_00FF, 1'b0, 1'b1, 1'b1, 1'b0, a);
      cycle(1'b1, 32'hFFFF_0000, 1'b1, 1'b1, 1'b1, 1'b0, a);
      chk("acc_no_early_valid", out_valid, 0);
      idle(1'b1);
      chk("acc_valid", out_valid, 1);
      chk("acc_count", out_count, 28);
      chk("acc_sat", out_sat, 0);
      idle(1'b1);

      // saturation on the narrow instance
      for (int i = 0; i < 3; i++) cycle(1'b1, 32'hFFFF_FFFF, i == 2, 1'b1, 1'b1, 1'b0, a);
      idle(1'b1);
      chk("sat6_valid", out_valid6, 1);
      chk("sat6_count", out_count6, 63);
      chk("sat6_flag", out_sat6, 1);
      chk("sat16_count", out_count, 96);
      chk("sat16_flag", out_sat, 0);
      cycle(1'b1, 32'h0000_0003, 1'b1, 1'b1, 1'b1, 1'b0, a);
      idle(1'b1);
      chk("post_sat_count6", out_count6, 2);
      chk("post_sat_flag6", out_sat6, 0);
      idle(1'b1);

      // clr mid-frame
      cycle(1'b1, 32'h0000_00FF, 1'b0, 1'b1, 1'b1, 1'b0, a);
      cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, a);
      cycle(1'b1, 32'h0000_0001, 1'b1, 1'b1, 1'b1, 1'b0, a);
      idle(1'b1);
      chk("clr_valid", out_valid, 1);
      chk("clr_count", out_count, 1);
      chk("clr_sat", out_sat, 0);
      idle(1'b1);

      // reset mid-frame
      cycle(1'b1, 32'h0000_00FF, 1'b0, 1'b1, 1'b1, 1'b0, a);
      cycle(1'b1, 32'h0000_0F00, 1'b0, 1'b1, 1'b1, 1'b0, a);
      do_reset();
      cycle(1'b1, 32'h0000_000F, 1'b1, 1'b1, 1'b1, 1'b0, a);
      idle(1'b1);
      chk("rst_frame_valid", out_valid, 1);
      chk("rst_frame_count", out_count, 4);
      idle(1'b1);

      // backpressure: consumer stalls for 5 cycles mid-stream
      for (int i = 0; i < 8; i++) beats[i] = $urandom;
      idx = 0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         if (cyc == 5) begin
            chk("bp_out_held_valid", out_valid, 1);
            chk("bp_in_ready_low", in_ready, 0);
         end
         cycle(idx < 8, (idx < 8) ? beats[idx] : 32'h0, 1'b0, 1'b0,
               !(cyc >= 2 && cyc < 7), 1'b0, a);
         if (a) idx++;
      end
      chk("bp_all_accepted", idx, 8);
      chk("bp_all_delivered", exp_q.size(), 0);

      // randomized traffic
      for (int cyc = 0; cyc < 1500; cyc++) begin
         logic [31:0] d;
         d = $urandom;
         if ($urandom_range(0, 7) == 0) d = 32'hFFFF_FFFF;
         cycle($urandom_range(0, 3) != 0, d, $urandom_range(0, 3) == 0,
               $urandom_range(0, 2) != 0, $urandom_range(0, 9) < 7,
               $urandom_range(0, 79) == 0, a);
      end
      for (int i = 0; i < 10; i++) idle(1'b1);
      chk("drain_queue_empty", exp_q.size(), 0);
      chk("drain_out_valid", out_valid, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
